imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader: the write side of the instruction memory port that the CPU top only reads (data_in/wr/addr/enable).
- Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit words.
- Writes those words to instruction memory at consecutive even byte addresses.
- Holds the CPU in reset for the whole load.

Parameters:
- BASE_ADDR, 16'h0000, byte address of the first word written; must be even.
- MAX_WORDS, 16'd32768, largest word count accepted; larger header counts are clamped.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- byte_data  in  8  incoming stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- im_data_in  out  16  word written to instruction memory.
- im_addr  out  16  instruction memory byte address.
- im_enable  out  1  memory enable.
- im_wr  out  1  memory write strobe.
- cpu_hold  out  1  high while loading; CPU reset is rst OR cpu_hold.
- busy  out  1  high in any state other than IDLE or DONE.
- done  out  1  high in DONE.
- clamped  out  1  header count exceeded MAX_WORDS; sticky until the next start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0 except cpu_hold=1.
  - Word counter, word index and byte latch are cleared.
  - A CPU must not run from an unloaded memory.
- Byte transfer occurs on a rising clk when byte_valid && byte_ready. byte_ready is registered-state decoded: 1 only in HDR_HI, HDR_LO, DAT_HI, DAT_LO.
- Stream format: header word (count N, high byte first), then N data words (high byte first).
- FSM states: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, DONE.
  - IDLE: cpu_hold=1. On start, go to HDR_HI and clear clamped.
  - HDR_HI: on transfer, latch the high byte and go to HDR_LO.
  - HDR_LO: on transfer, form N.
    - N=0: go to DONE.
    - N>MAX_WORDS: count=MAX_WORDS, clamped=1, go to DAT_HI.
    - Otherwise: count=N, index=0, go to DAT_HI.
  - DAT_HI: on transfer, latch the high byte and go to DAT_LO.
  - DAT_LO: on transfer, register im_data_in={hi,lo} and im_addr=BASE_ADDR+(index<<1); go to WRITE.
  - WRITE (exactly one cycle):
    - im_enable=1, im_wr=1, byte_ready=0.
    - index increments.
    - If index+1==count go to DONE, else go to DAT_HI.
  - DONE: cpu_hold=0, done=1. A start pulse here restarts at HDR_HI and re-asserts cpu_hold the next cycle.
- Strobe timing:
  - im_wr/im_enable are high only in WRITE. im_addr/im_data_in are stable for that whole cycle.
  - Outside WRITE, im_addr/im_data_in hold their last value and im_enable=0.
- Byte stalls: byte_valid low in any receive state keeps the state. There is no timeout.
- start while busy is ignored.
- Address wrap: im_addr is 16-bit modulo. BASE_ADDR+2*(count-1) past 16'hFFFE wraps to 0; no error is flagged.
- Latency:
  - First im_wr occurs 1 cycle after the 4th accepted byte (header plus the first data word).
  - Steady state is 3 cycles per word at full valid.
- Reset mid-load: immediately returns to the IDLE values. Partial memory contents are left as written; cpu_hold=1.

Test Plan:
- Reset, start, stream 00 02 12 34 AB CD with valid held high:
  - im_wr is high for one cycle at addr 0x0000 data 0x1234, then one cycle at 0x0002 data 0xABCD.
  - done=1 and cpu_hold=0 on the cycle after the second WRITE.
  - Exactly 2 im_wr pulses in total.
- BASE_ADDR=16'h0100, N=1, data 0xF000:
  - Single write at 0x0100.
  - byte_ready=0 in the WRITE cycle.
  - busy drops as done rises.
- Header 00 00:
  - DONE directly, zero im_wr pulses.
  - done=1 the cycle after the 2nd byte.
- MAX_WORDS=4, header 00 09, then 8 data bytes:
  - clamped=1, exactly 4 writes at 0,2,4,6, then DONE.
  - byte_ready=0 afterwards; extra bytes are not consumed.
- Random byte_valid gaps (0–5 cycles) on a 3-word load:
  - Identical addr/data sequence to the gap-free run.
  - No byte is accepted while byte_ready=0.
- Assert rst during DAT_LO of word 2:
  - Outputs go to reset values asynchronously; cpu_hold=1, done=0.
  - A subsequent start plus a full stream loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory program loader: takes a big-endian byte stream (word count
// header, then data words) and writes 16-bit words to consecutive even addresses.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] im_data_in,
    output logic [15:0] im_addr,
    output logic        im_enable,
    output logic        im_wr,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        clamped
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [15:0] data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic        clamped_q, clamped_d;
    logic        xfer;
    logic [15:0] rx_word;

    assign byte_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                        (state_q == DAT_HI) || (state_q == DAT_LO);
    assign xfer       = byte_valid && byte_ready;
    assign rx_word    = {hi_q, byte_data};

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        count_d   = count_q;
        index_d   = index_q;
        data_d    = data_q;
        addr_d    = addr_q;
        clamped_d = clamped_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = HDR_HI;
                    clamped_d = 1'b0;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    if (rx_word == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        index_d = '0;
                        state_d = DAT_HI;
                        if (rx_word > MAX_WORDS) begin
                            count_d   = MAX_WORDS;
                            clamped_d = 1'b1;
                        end else begin
                            count_d = rx_word;
                        end
                    end
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    data_d  = rx_word;
                    // Byte address of word index; 16-bit wrap is intentional.
                    addr_d  = BASE_ADDR + {index_q[14:0], 1'b0};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                index_d = index_q + 16'd1;
                if (index_q + 16'd1 == count_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DAT_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            count_q   <= '0;
            index_q   <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            count_q   <= count_d;
            index_q   <= index_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            clamped_q <= clamped_d;
        end
    end

    assign im_data_in = data_q;
    assign im_addr    = addr_q;
    assign im_enable  = (state_q == WRITE);
    assign im_wr      = (state_q == WRITE);
    assign cpu_hold   = (state_q != DONE);
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign clamped    = clamped_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (default parameters, and a
// wrapping base with a small word limit) share one randomized byte stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        sel;
    logic        valid_a, valid_b;

    logic        rdy_a, en_a, wr_a, hold_a, busy_a, done_a, clamp_a;
    logic [15:0] data_a, addr_a;
    logic        rdy_b, en_b, wr_b, hold_b, busy_b, done_b, clamp_b;
    logic [15:0] data_b, addr_b;

    logic        m_rdy, m_en, m_wr, m_hold, m_busy, m_done, m_clamp;
    logic [15:0] m_data, m_addr;

    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          writes_seen = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign valid_a = byte_valid && !sel;
    assign valid_b = byte_valid && sel;

    imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd32768)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .byte_data(byte_data),
        .byte_valid(valid_a), .byte_ready(rdy_a), .im_data_in(data_a),
        .im_addr(addr_a), .im_enable(en_a), .im_wr(wr_a), .cpu_hold(hold_a),
        .busy(busy_a), .done(done_a), .clamped(clamp_a)
    );

    imem_loader #(.BASE_ADDR(16'hFFFC), .MAX_WORDS(16'd4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .byte_data(byte_data),
        .byte_valid(valid_b), .byte_ready(rdy_b), .im_data_in(data_b),
        .im_addr(addr_b), .im_enable(en_b), .im_wr(wr_b), .cpu_hold(hold_b),
        .busy(busy_b), .done(done_b), .clamped(clamp_b)
    );

    assign m_rdy   = sel ? rdy_b   : rdy_a;
    assign m_en    = sel ? en_b    : en_a;
    assign m_wr    = sel ? wr_b    : wr_a;
    assign m_hold  = sel ? hold_b  : hold_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_clamp = sel ? clamp_b : clamp_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_addr  = sel ? addr_b  : addr_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word list is the header count (clamped), addresses base+2i mod 2^16.
    task automatic model(input logic [7:0] b[$], input logic [15:0] base,
                         input logic [15:0] maxw, output int cnt, output bit clmp);
        int n;
        logic [15:0] a;
        n    = (int'(b[0]) << 8) | int'(b[1]);
        clmp = (n > int'(maxw));
        cnt  = clmp ? int'(maxw) : n;
        for (int i = 0; i < cnt; i++) begin
            a = base + 16'(2 * i);
            exp_q.push_back({a, b[2 + 2 * i], b[3 + 2 * i]});
        end
    endtask

    // Monitor: every write strobe pops one expected {addr,data} entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_rdy && byte_valid) accepted++;
            if (m_wr) begin
                logic [31:0] e;
                writes_seen++;
                chk("wr_enable", {31'd0, m_en}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {m_addr, m_data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {16'd0, m_addr}, {16'd0, e[31:16]});
                    chk("wr_data", {16'd0, m_data}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic run_load(input bit s, input logic [7:0] b[$], input int maxgap,
                            input int extra, input int abort_at);
        int  cnt;
        bit  clmp;
        int  need;
        int  gap;
        bit  r;
        bit  got;
        sel = s;
        exp_q.delete();
        model(b, s ? 16'hFFFC : 16'h0000, s ? 16'd4 : 16'd32768, cnt, clmp);
        need        = 2 + 2 * cnt;
        accepted    = 0;
        writes_seen = 0;
        @(posedge clk); #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_busy",  {31'd0, m_busy}, 32'd1);
        chk("start_hold",  {31'd0, m_hold}, 32'd1);
        chk("start_done",  {31'd0, m_done}, 32'd0);
        chk("start_clamp", {31'd0, m_clamp}, 32'd0);
        for (int i = 0; i < need; i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            byte_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            byte_data  = b[i];
            byte_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                r = m_rdy;
                @(posedge clk);
                got = r;
            end
            #1;
            byte_valid = 1'b0;
            if (!got) begin
                chk("accept_timeout", 32'd0, 32'd1);
                return;
            end
            if (i == abort_at) return;
            if (i == 1 && cnt == 0) begin
                @(negedge clk);
                chk("zero_done", {31'd0, m_done}, 32'd1);
                chk("zero_hold", {31'd0, m_hold}, 32'd0);
            end
            if (i >= 3 && (i % 2) == 1) begin
                @(negedge clk);
                chk("write_strobe", {31'd0, m_wr}, 32'd1);
                chk("write_rdy",    {31'd0, m_rdy}, 32'd0);
                chk("write_hold",   {31'd0, m_hold}, 32'd1);
                if (i == need - 1) begin
                    @(negedge clk);
                    chk("end_done",  {31'd0, m_done}, 32'd1);
                    chk("end_hold",  {31'd0, m_hold}, 32'd0);
                    chk("end_busy",  {31'd0, m_busy}, 32'd0);
                    chk("end_clamp", {31'd0, m_clamp}, {31'd0, clmp});
                end
            end
        end
        byte_data  = 8'h5A;
        byte_valid = 1'b1;
        repeat (extra) @(negedge clk);
        byte_valid = 1'b0;
        chk("bytes_accepted", accepted, need);
        chk("write_count", writes_seen, cnt);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hold"},  {31'd0, m_hold}, 32'd1);
        chk({tag, "_done"},  {31'd0, m_done}, 32'd0);
        chk({tag, "_busy"},  {31'd0, m_busy}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, m_rdy}, 32'd0);
        chk({tag, "_wr"},    {30'd0, m_wr, m_en}, 32'd0);
        chk({tag, "_addr"},  {16'd0, m_addr}, 32'd0);
        chk({tag, "_data"},  {16'd0, m_data}, 32'd0);
        chk({tag, "_clamp"}, {31'd0, m_clamp}, 32'd0);
    endtask

    initial begin
        logic [7:0] b[$];
        logic [7:0] w3[$];
        int n;
        bit s;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        byte_data = 8'h00; byte_valid = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_a");
        sel = 1'b1; #1;
        chk_reset_vals("rst_b");
        sel = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_load(1'b0, b, 0, 3, -1);
        b = '{8'h00, 8'h00};
        run_load(1'b0, b, 0, 4, -1);
        b = '{8'h00, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(1'b1, b, 0, 5, -1);

        w3 = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hF0, 8'h0D};
        run_load(1'b0, w3, 0, 2, -1);
        run_load(1'b0, w3, 5, 2, -1);

        // Abort while word 2 is half received, then reload from scratch.
        run_load(1'b0, w3, 0, 0, 4);
        #2 rst = 1'b1;
        #1 chk_reset_vals("mid_rst");
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        run_load(1'b0, w3, 0, 2, -1);

        for (int k = 0; k < 8; k++) begin
            s = 1'($urandom_range(1, 0));
            n = int'($urandom_range(s ? 9 : 6, 0));
            b = {};
            b.push_back(8'(n >> 8));
            b.push_back(8'(n));
            for (int j = 0; j < 2 * n; j++) b.push_back(8'($urandom));
            run_load(s, b, int'($urandom_range(3, 0)), 3, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
